anneal_sequencer: RTL and testbench

Top-level run controller for the replica-exchange node array. It turns one host `start` into a complete annealing run:
- seed the random generators;
- repeat `iter_num` times: opt phase, exp (Metropolis) phase, replica-exchange strobe with alternating even/odd pairing;
- unload the total distances and orderings through the shift chains;
- pulse `done`.

All outputs fan out unchanged to every node, so all nodes step in lock-step.

---
 rtl/anneal_sequencer.sv | 170 +++++++++++++++++
 tb/tb_anneal_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/anneal_sequencer.sv
// Run controller: seed, iterate opt/exp/exchange, unload chains, pulse done; all nodes step in lock-step.
// Outputs decode the state register (one cycle after the sampling edge); no backpressure, abort cancels at the next edge.
module anneal_sequencer #(
    parameter int NODE_NUM   = 32,
    parameter int ORD_LEN    = 32,
    parameter int OPT_CYCLES = 16,
    parameter int EXP_CYCLES = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] iter_num,
    input  logic [16:0] recip_in,
    output logic        random_init,
    output logic        opt_run,
    output logic        exp_init,
    output logic        exp_run,
    output logic        exp_fin,
    output logic [16:0] exp_recip,
    output logic        exchange_run,
    output logic        exchange_phase,
    output logic        distance_shift,
    output logic        exchange_shift_d,
    output logic        busy,
    output logic        done,
    output logic [15:0] iter_cnt
);

    localparam int MAX_AB  = (NODE_NUM > ORD_LEN) ? NODE_NUM : ORD_LEN;
    localparam int MAX_CD  = (OPT_CYCLES > EXP_CYCLES) ? OPT_CYCLES : EXP_CYCLES;
    localparam int MAX_LEN = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = $clog2(MAX_LEN) + 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SEED,
        S_OPT,
        S_EXP_I,
        S_EXP_R,
        S_EXP_F,
        S_EXCH,
        S_DUMP_DIS,
        S_DUMP_ORD,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [15:0] iter_num;
        logic [16:0] recip;
    } run_cfg_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    run_cfg_t        cfg;
    logic            capture;
    logic            exch_exit;
    logic [15:0]     iter_cnt_q;
    logic            phase_q;
    logic [15:0]     iter_cnt_inc;

    assign iter_cnt_inc = iter_cnt_q + 16'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            cfg        <= '0;
            iter_cnt_q <= '0;
            phase_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (capture) begin
                cfg.iter_num <= iter_num;
                cfg.recip    <= recip_in;
                iter_cnt_q   <= '0;
                phase_q      <= 1'b0;
            end else if (exch_exit) begin
                iter_cnt_q <= iter_cnt_inc;
                phase_q    <= ~phase_q;
            end
        end
    end

    // Shared down-counter: loaded with length-1 on entry, state exits when it reads 0.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt != '0) ? cnt - CW'(1) : cnt;
        capture   = 1'b0;
        exch_exit = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_SEED;
                    capture   = 1'b1;
                end
            end
            S_SEED: begin
                if (cfg.iter_num == 16'd0) begin
                    state_nxt = S_DUMP_DIS;
                    cnt_nxt   = CW'(NODE_NUM - 1);
                end else begin
                    state_nxt = S_OPT;
                    cnt_nxt   = CW'(OPT_CYCLES - 1);
                end
            end
            S_OPT: begin
                if (cnt == '0) state_nxt = S_EXP_I;
            end
            S_EXP_I: begin
                state_nxt = S_EXP_R;
                cnt_nxt   = CW'(EXP_CYCLES - 1);
            end
            S_EXP_R: begin
                if (cnt == '0) state_nxt = S_EXP_F;
            end
            S_EXP_F: begin
                state_nxt = S_EXCH;
            end
            S_EXCH: begin
                exch_exit = 1'b1;
                if (iter_cnt_inc == cfg.iter_num) begin
                    state_nxt = S_DUMP_DIS;
                    cnt_nxt   = CW'(NODE_NUM - 1);
                end else begin
                    state_nxt = S_OPT;
                    cnt_nxt   = CW'(OPT_CYCLES - 1);
                end
            end
            S_DUMP_DIS: begin
                if (cnt == '0) begin
                    state_nxt = S_DUMP_ORD;
                    cnt_nxt   = CW'(ORD_LEN - 1);
                end
            end
            S_DUMP_ORD: begin
                if (cnt == '0) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        // An aborted EXCH does not count as a completed iteration.
        if (abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
            exch_exit = 1'b0;
        end
    end

    assign random_init      = (state == S_SEED);
    assign opt_run          = (state == S_OPT);
    assign exp_init         = (state == S_EXP_I);
    assign exp_run          = (state == S_EXP_R);
    assign exp_fin          = (state == S_EXP_F);
    assign exchange_run     = (state == S_EXCH);
    assign distance_shift   = (state == S_DUMP_DIS);
    assign exchange_shift_d = (state == S_DUMP_ORD);
    assign done             = (state == S_DONE);
    assign busy             = (state != S_IDLE);
    assign exp_recip        = cfg.recip;
    assign exchange_phase   = phase_q;
    assign iter_cnt         = iter_cnt_q;

endmodule

// File: tb/tb_anneal_sequencer.sv
// Scoreboard bench for anneal_sequencer: expected per-cycle strobes queued at start, popped by a negedge monitor.
module tb_anneal_sequencer;

    localparam logic [8:0] RI = 9'b000000001;
    localparam logic [8:0] OP = 9'b000000010;
    localparam logic [8:0] EI = 9'b000000100;
    localparam logic [8:0] ER = 9'b000001000;
    localparam logic [8:0] EF = 9'b000010000;
    localparam logic [8:0] EX = 9'b000100000;
    localparam logic [8:0] DS = 9'b001000000;
    localparam logic [8:0] SD = 9'b010000000;
    localparam logic [8:0] DN = 9'b100000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] iter_num = '0;
    logic [16:0] recip_in = '0;
    logic        random_init, opt_run, exp_init, exp_run, exp_fin;
    logic [16:0] exp_recip;
    logic        exchange_run, exchange_phase, distance_shift, exchange_shift_d;
    logic        busy, done;
    logic [15:0] iter_cnt;

    anneal_sequencer #(
        .NODE_NUM(32), .ORD_LEN(32), .OPT_CYCLES(16), .EXP_CYCLES(17)
    ) dut (
        .clk(clk), .reset(rst_n), .start(start), .abort(abort),
        .iter_num(iter_num), .recip_in(recip_in),
        .random_init(random_init), .opt_run(opt_run),
        .exp_init(exp_init), .exp_run(exp_run), .exp_fin(exp_fin),
        .exp_recip(exp_recip), .exchange_run(exchange_run),
        .exchange_phase(exchange_phase), .distance_shift(distance_shift),
        .exchange_shift_d(exchange_shift_d), .busy(busy), .done(done),
        .iter_cnt(iter_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  strb;
        logic        ph;
        logic [15:0] ic;
        logic [16:0] rc;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   e0 = 0;
    int   exp_done_cyc = 0;

    int          g_c, g_lim;
    logic        g_ph;
    logic [15:0] g_ic;
    logic [16:0] g_rc;

    always @(posedge clk) cyc++;

    function automatic logic [8:0] strobes();
        return {done, exchange_shift_d, distance_shift, exchange_run,
                exp_fin, exp_run, exp_init, opt_run, random_init};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc - e0);
        end
    endtask

    task automatic push(input logic [8:0] s);
        if (g_c < g_lim) begin
            g_c++;
            exp_q.push_back('{strb: s, ph: g_ph, ic: g_ic, rc: g_rc, cyc: g_c});
        end
    endtask

    // Expected output sequence for a run of n iterations, truncated after 'limit' cycles.
    task automatic gen_run(input int n, input logic [16:0] rc, input int limit);
        g_c = 0; g_lim = limit; g_ph = 1'b0; g_ic = '0; g_rc = rc;
        push(RI);
        for (int k = 0; k < n; k++) begin
            repeat (16) push(OP);
            push(EI);
            repeat (17) push(ER);
            push(EF);
            push(EX);
            g_ph = ~g_ph;
            g_ic = g_ic + 16'd1;
        end
        repeat (32) push(DS);
        repeat (32) push(SD);
        push(DN);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (busy || (strobes() != '0)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got strobes %0h busy %0b expected idle (cycle %0d)",
                         strobes(), busy, cyc - e0);
            end else begin
                e = exp_q.pop_front();
                chk("strobes", 32'(strobes()), 32'(e.strb));
                chk("cycle", cyc - e0, e.cyc);
                chk("busy", 32'(busy), 1);
                chk("iter_cnt", 32'(iter_cnt), 32'(e.ic));
                chk("exchange_phase", 32'(exchange_phase), 32'(e.ph));
                chk("exp_recip", 32'(exp_recip), 32'(e.rc));
                if (done) chk("done_cycle", cyc - e0, exp_done_cyc);
            end
        end
    end

    task automatic do_start(input logic [15:0] n, input logic [16:0] rc, input logic ab);
        @(negedge clk);
        iter_num = n; recip_in = rc; start = 1'b1; abort = ab; e0 = cyc;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic wait_rel(input int r);
        while ((cyc - e0) < r) @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        chk("queue_drained", exp_q.size(), 0);
        @(negedge clk);
        chk("busy_after_run", 32'(busy), 0);
        chk("idle_strobes", 32'(strobes()), 0);
    endtask

    initial begin
        // Reset held: everything zero.
        repeat (3) @(negedge clk);
        chk("rst_strobes", 32'(strobes()), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_iter_cnt", 32'(iter_cnt), 0);
        chk("rst_recip", 32'(exp_recip), 0);
        chk("rst_phase", 32'(exchange_phase), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_quiet", 32'({strobes(), busy, exchange_phase}), 0);
        end

        // Single iteration.
        gen_run(1, 17'h1abcd, 1000);
        exp_done_cyc = 102;
        do_start(16'd1, 17'h1abcd, 1'b0);
        drain(200);
        chk("single_iter_cnt_held", 32'(iter_cnt), 1);
        chk("single_recip_held", 32'(exp_recip), 32'h1abcd);

        // Three iterations.
        gen_run(3, 17'h00123, 1000);
        exp_done_cyc = 174;
        do_start(16'd3, 17'h00123, 1'b0);
        drain(300);
        chk("multi_iter_cnt_held", 32'(iter_cnt), 3);

        // Zero iterations.
        gen_run(0, 17'h0ffff, 1000);
        exp_done_cyc = 66;
        do_start(16'd0, 17'h0ffff, 1'b0);
        drain(150);
        chk("zero_iter_cnt", 32'(iter_cnt), 0);

        // Abort in 5th exp_run cycle of iteration 2 (cycle 59).
        gen_run(3, 17'h00042, 59);
        exp_done_cyc = -1;
        do_start(16'd3, 17'h00042, 1'b0);
        wait_rel(59);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_strobes", 32'(strobes()), 0);
        chk("abort_iter_cnt", 32'(iter_cnt), 1);
        chk("abort_queue", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        chk("abort_no_done", 32'({done, busy}), 0);

        // Restart with abort and start together in IDLE: start wins.
        gen_run(2, 17'h00077, 1000);
        exp_done_cyc = 1 + 2 * 36 + 64 + 1;
        do_start(16'd2, 17'h00077, 1'b1);
        drain(250);
        chk("restart_iter_cnt", 32'(iter_cnt), 2);

        // Ignored start during OPT, then reset in DUMP_ORD (cycle 80).
        gen_run(1, 17'h10001, 80);
        exp_done_cyc = 102;
        do_start(16'd1, 17'h10001, 1'b0);
        wait_rel(5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_rel(80);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_strobes", 32'(strobes()), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_iter_cnt", 32'(iter_cnt), 0);
        chk("midrst_recip", 32'(exp_recip), 0);
        chk("midrst_phase", 32'(exchange_phase), 0);
        chk("midrst_queue", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_quiet", 32'({strobes(), busy}), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
